// File: rtl/mbldcm_multi_pkg.sv
// Shared definitions for the multi-channel BLDC commutation controller:
// register map, bit positions, response codes, channel state and commutation table.
package mbldcm_multi_pkg;

    localparam logic [1:0] cRegCtrl    = 2'd0;
    localparam logic [1:0] cRegTarget  = 2'd1;
    localparam logic [1:0] cRegCurrent = 2'd2;
    localparam logic [1:0] cRegStatus  = 2'd3;

    localparam int cCtrlEnable = 0;
    localparam int cCtrlDir    = 1;
    localparam int cCtrlBrake  = 2;

    localparam int cStatAtTarget = 8;
    localparam int cStatRunning  = 9;
    localparam int cStatDeadtime = 10;

    localparam logic [1:0] cRespOkay   = 2'b00;
    localparam logic [1:0] cRespSlvErr = 2'b10;

    typedef enum logic [1:0] {
        stIdle,
        stDrive,
        stDead,
        stBrake
    } tChanState;

    // Gate vector order is {Uh, Ul, Vh, Vl, Wh, Wl}.
    function automatic logic [5:0] fCommTable(input logic [2:0] phase, input logic brake);
        logic [5:0] gates;
        gates = 6'b000000;
        if (brake) begin
            gates = 6'b010101;
        end else begin
            case (phase)
                3'd0:    gates = 6'b100100;
                3'd1:    gates = 6'b100001;
                3'd2:    gates = 6'b001001;
                3'd3:    gates = 6'b011000;
                3'd4:    gates = 6'b010010;
                3'd5:    gates = 6'b000110;
                default: gates = 6'b000000;
            endcase
        end
        return gates;
    endfunction

endpackage

// File: rtl/mbldcm_multi_channel.sv
// One motor channel: 6-step commutation FSM with step counter, period ramp,
// dead-time insertion and brake, driving registered gate outputs.
module mbldcm_multi_channel
    import mbldcm_multi_pkg::*;
#(
    parameter int          pPeriodWidth = 24,
    parameter int unsigned pStartPeriod = 500000,
    parameter int unsigned pRampStep    = 256,
    parameter int unsigned pDeadTime    = 10
) (
    input  logic                    iClock,
    input  logic                    iReset_n,
    input  logic                    iEnable,
    input  logic                    iDir,
    input  logic                    iBrake,
    input  logic [pPeriodWidth-1:0] iTarget,
    output logic [pPeriodWidth-1:0] oCurrent,
    output logic [2:0]              oPhase,
    output logic                    oRunning,
    output logic                    oInDeadtime,
    output logic                    oAtTarget,
    output logic [5:0]              oGates
);

    localparam logic [pPeriodWidth-1:0] cStart = pPeriodWidth'(pStartPeriod);
    localparam logic [pPeriodWidth-1:0] cStep  = pPeriodWidth'(pRampStep);
    localparam logic [pPeriodWidth-1:0] cOne   = pPeriodWidth'(1);
    localparam logic [7:0]              cDead  = 8'(pDeadTime);

    tChanState               state;
    logic [pPeriodWidth-1:0] current;
    logic [pPeriodWidth-1:0] counter;
    logic [7:0]              deadCnt;
    logic [2:0]              phase;
    logic [pPeriodWidth-1:0] rampNext;
    logic [2:0]              phaseNext;

    // NOTE: combinational blocks assign every output first so no latch is inferred.
    always_comb begin
        rampNext = iTarget;
        if (current > iTarget) begin
            if (current - iTarget > cStep) rampNext = current - cStep;
        end else if (iTarget - current > cStep) begin
            rampNext = current + cStep;
        end
    end

    always_comb begin
        if (iDir) phaseNext = (phase == 3'd0) ? 3'd5 : phase - 3'd1;
        else      phaseNext = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all branches read pre-edge values.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state   <= stIdle;
            current <= cStart;
            counter <= cStart;
            deadCnt <= 8'd0;
            phase   <= 3'd0;
            oGates  <= 6'b000000;
        end else if (!iEnable) begin
            state  <= stIdle;
            oGates <= 6'b000000;
        end else if (iBrake) begin
            // Counter is held while braking; leaving IDLE still restarts the period.
            state  <= stBrake;
            oGates <= fCommTable(phase, 1'b1);
            if (state == stIdle) begin
                current <= cStart;
                counter <= cStart;
            end
        end else begin
            case (state)
                stIdle: begin
                    current <= cStart;
                    counter <= cStart;
                    state   <= stDrive;
                    oGates  <= fCommTable(phase, 1'b0);
                end
                stDrive: begin
                    if (counter <= cOne) begin
                        phase   <= phaseNext;
                        current <= rampNext;
                        if (cDead == 8'd0) begin
                            counter <= rampNext;
                            oGates  <= fCommTable(phaseNext, 1'b0);
                        end else begin
                            state   <= stDead;
                            deadCnt <= cDead;
                            oGates  <= 6'b000000;
                        end
                    end else begin
                        counter <= counter - cOne;
                        oGates  <= fCommTable(phase, 1'b0);
                    end
                end
                stDead: begin
                    if (deadCnt <= 8'd1) begin
                        state   <= stDrive;
                        counter <= current;
                        oGates  <= fCommTable(phase, 1'b0);
                    end else begin
                        deadCnt <= deadCnt - 8'd1;
                        oGates  <= 6'b000000;
                    end
                end
                default: begin
                    if (cDead == 8'd0) begin
                        state   <= stDrive;
                        counter <= current;
                        oGates  <= fCommTable(phase, 1'b0);
                    end else begin
                        state   <= stDead;
                        deadCnt <= cDead;
                        oGates  <= 6'b000000;
                    end
                end
            endcase
        end
    end

    // at_target is only reported while the channel is running, so an idle channel reads status 0.
    assign oCurrent    = current;
    assign oPhase      = phase;
    assign oRunning    = (state != stIdle);
    assign oInDeadtime = (state == stDead);
    assign oAtTarget   = oRunning && (current == iTarget);

endmodule

// File: rtl/mbldcm_multi.sv
// Multi-channel BLDC controller top: Avalon-MM register file and decode,
// one commutation channel per motor.
module mbldcm_multi
    import mbldcm_multi_pkg::*;
#(
    parameter int          pChannels    = 2,
    parameter int          pPeriodWidth = 24,
    parameter int unsigned pStartPeriod = 500000,
    parameter int unsigned pMinPeriod   = 1000,
    parameter int unsigned pRampStep    = 256,
    parameter int unsigned pDeadTime    = 10
) (
    input  logic                         iClock,
    input  logic                         iReset_n,
    input  logic [$clog2(pChannels)+1:0] iAddr,
    input  logic                         iRead,
    output logic [31:0]                  oRdata,
    input  logic                         iWrite,
    input  logic [31:0]                  iWdata,
    output logic [1:0]                   oResp,
    output logic [pChannels-1:0]         oUh,
    output logic [pChannels-1:0]         oUl,
    output logic [pChannels-1:0]         oVh,
    output logic [pChannels-1:0]         oVl,
    output logic [pChannels-1:0]         oWh,
    output logic [pChannels-1:0]         oWl
);

    localparam logic [pPeriodWidth-1:0] cStart = pPeriodWidth'(pStartPeriod);
    localparam logic [pPeriodWidth-1:0] cMin   = pPeriodWidth'(pMinPeriod);

    logic [2:0]              ctrlReg    [pChannels];
    logic [pPeriodWidth-1:0] targetReg  [pChannels];
    logic [pPeriodWidth-1:0] chCurrent  [pChannels];
    logic [2:0]              chPhase    [pChannels];
    logic                    chRunning  [pChannels];
    logic                    chInDead   [pChannels];
    logic                    chAtTarget [pChannels];
    logic [5:0]              chGates    [pChannels];

    logic [3:0]              addrPad;
    logic [1:0]              reqChan;
    logic [1:0]              reqReg;
    logic                    chanOk;
    logic [pPeriodWidth-1:0] wrTarget;
    logic [31:0]             rdMux;
    logic                    unusedWdata;

    // Zero-extending the address gives one decode for every channel count.
    assign addrPad     = 4'(iAddr);
    assign reqChan     = addrPad[3:2];
    assign reqReg      = addrPad[1:0];
    assign chanOk      = (int'(reqChan) < pChannels);
    assign wrTarget    = (iWdata[pPeriodWidth-1:0] < cMin) ? cMin : iWdata[pPeriodWidth-1:0];
    assign unusedWdata = ^iWdata;

    always_comb begin
        rdMux = '0;
        for (int c = 0; c < pChannels; c++) begin
            if (int'(reqChan) == c) begin
                case (reqReg)
                    cRegCtrl:    rdMux = {29'b0, ctrlReg[c]};
                    cRegTarget:  rdMux = 32'(targetReg[c]);
                    cRegCurrent: rdMux = 32'(chCurrent[c]);
                    default: begin
                        rdMux[2:0]           = chPhase[c];
                        rdMux[cStatAtTarget] = chAtTarget[c];
                        rdMux[cStatRunning]  = chRunning[c];
                        rdMux[cStatDeadtime] = chInDead[c];
                    end
                endcase
            end
        end
    end

    // NOTE: the register arrays are tiny control registers, so they take a full reset like any flop.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            oRdata <= '0;
            oResp  <= cRespOkay;
            for (int c = 0; c < pChannels; c++) begin
                ctrlReg[c]   <= 3'b000;
                targetReg[c] <= cStart;
            end
        end else if (iWrite) begin
            oRdata <= '0;
            oResp  <= cRespSlvErr;
            for (int c = 0; c < pChannels; c++) begin
                if (int'(reqChan) == c) begin
                    if (reqReg == cRegCtrl) begin
                        ctrlReg[c] <= iWdata[cCtrlBrake:0];
                        oResp      <= cRespOkay;
                    end else if (reqReg == cRegTarget) begin
                        targetReg[c] <= wrTarget;
                        oResp        <= cRespOkay;
                    end
                end
            end
        end else if (iRead) begin
            oRdata <= chanOk ? rdMux : '0;
            oResp  <= chanOk ? cRespOkay : cRespSlvErr;
        end
    end

    for (genvar g = 0; g < pChannels; g++) begin : gChan
        mbldcm_multi_channel #(
            .pPeriodWidth(pPeriodWidth),
            .pStartPeriod(pStartPeriod),
            .pRampStep   (pRampStep),
            .pDeadTime   (pDeadTime)
        ) uChan (
            .iClock     (iClock),
            .iReset_n   (iReset_n),
            .iEnable    (ctrlReg[g][cCtrlEnable]),
            .iDir       (ctrlReg[g][cCtrlDir]),
            .iBrake     (ctrlReg[g][cCtrlBrake]),
            .iTarget    (targetReg[g]),
            .oCurrent   (chCurrent[g]),
            .oPhase     (chPhase[g]),
            .oRunning   (chRunning[g]),
            .oInDeadtime(chInDead[g]),
            .oAtTarget  (chAtTarget[g]),
            .oGates     (chGates[g])
        );

        assign oUh[g] = chGates[g][5];
        assign oUl[g] = chGates[g][4];
        assign oVh[g] = chGates[g][3];
        assign oVl[g] = chGates[g][2];
        assign oWh[g] = chGates[g][1];
        assign oWl[g] = chGates[g][0];
    end

endmodule

// File: tb/tb_mbldcm_multi.sv
// Self-checking bench for mbldcm_multi: randomized motor runs against a step-schedule
// model, plus register-map, brake and reset-recovery scenarios.
module tb_mbldcm_multi;

    // Three channels make channel index 3 addressable but out of range.
    localparam int cCh    = 3;
    localparam int cW     = 24;
    localparam int cStart = 100;
    localparam int cMin   = 10;
    localparam int cStep  = 20;
    localparam int cDead  = 4;

    localparam int rCtrl = 0, rTarget = 1, rCurrent = 2, rStatus = 3;

    logic           iClock = 1'b0;
    logic           iReset_n = 1'b0;
    logic [3:0]     iAddr = '0;
    logic           iRead = 1'b0;
    logic [31:0]    oRdata;
    logic           iWrite = 1'b0;
    logic [31:0]    iWdata = '0;
    logic [1:0]     oResp;
    logic [cCh-1:0] oUh, oUl, oVh, oVl, oWh, oWl;

    int nAssert = 0;
    int nFail   = 0;

    mbldcm_multi #(
        .pChannels   (cCh),
        .pPeriodWidth(cW),
        .pStartPeriod(cStart),
        .pMinPeriod  (cMin),
        .pRampStep   (cStep),
        .pDeadTime   (cDead)
    ) dut (
        .iClock  (iClock),
        .iReset_n(iReset_n),
        .iAddr   (iAddr),
        .iRead   (iRead),
        .oRdata  (oRdata),
        .iWrite  (iWrite),
        .iWdata  (iWdata),
        .oResp   (oResp),
        .oUh     (oUh),
        .oUl     (oUl),
        .oVh     (oVh),
        .oVl     (oVl),
        .oWh     (oWh),
        .oWl     (oWl)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] addrOf(input int ch, input int rg);
        return 4'(ch * 4 + rg);
    endfunction

    function automatic logic [5:0] gatesOf(input int c);
        return {oUh[c], oUl[c], oVh[c], oVl[c], oWh[c], oWl[c]};
    endfunction

    // Legs: U=0, V=1, W=2. Each phase drives one high side and one low side.
    function automatic logic [5:0] legDrive(input int ph);
        int hiLeg[6] = '{0, 0, 1, 1, 2, 2};
        int loLeg[6] = '{1, 2, 2, 0, 0, 1};
        logic [5:0] g;
        g = '0;
        g[5 - 2 * hiLeg[ph]] = 1'b1;
        g[4 - 2 * loLeg[ph]] = 1'b1;
        return g;
    endfunction

    function automatic int rampTo(input int p, input int tgt);
        if (p > tgt) return (p - tgt > cStep) ? p - cStep : tgt;
        return (tgt - p > cStep) ? p + cStep : tgt;
    endfunction

    // Expected channel view after edge E+n, E being the edge where enable was written.
    // Step k drives for period p_k, then cDead all-off cycles; phase and period advance
    // when the dead gap begins.
    task automatic model(input int n, input bit dir, input int tgt, output logic [5:0] g,
                         output int cur, output int ph, output bit inDead, output bit running);
        int t, s, p, k, pn;
        g = '0; cur = cStart; ph = 0; inDead = 1'b0; running = (n >= 1);
        if (n < 1) return;
        t = n - 1; s = 0; p = cStart; k = 0;
        forever begin
            if (t < s + p) begin
                ph = dir ? (6 - k % 6) % 6 : k % 6;
                g = legDrive(ph); cur = p;
                return;
            end
            pn = rampTo(p, tgt);
            if (t < s + p + cDead) begin
                ph = dir ? (6 - (k + 1) % 6) % 6 : (k + 1) % 6;
                cur = pn; inDead = 1'b1;
                return;
            end
            s = s + p + cDead; p = pn; k++;
        end
    endtask

    function automatic logic [31:0] statusWord(input int ph, input bit atT, input bit run, input bit dd);
        logic [31:0] w;
        w = '0;
        w[2:0] = 3'(ph);
        w[8] = atT; w[9] = run; w[10] = dd;
        return w;
    endfunction

    task automatic checkGates(input string tag, input int activeCh, input logic [5:0] expG);
        for (int c = 0; c < cCh; c++) begin
            check(tag, 32'(gatesOf(c)), (c == activeCh) ? 32'(expG) : 32'd0);
            check("shoot", {29'b0, oUh[c] & oUl[c], oVh[c] & oVl[c], oWh[c] & oWl[c]}, 32'd0);
        end
    endtask

    task automatic doReset();
        iReset_n = 1'b0;
        repeat (2) @(negedge iClock);
        iReset_n = 1'b1;
    endtask

    task automatic busWrite(input int ch, input int rg, input logic [31:0] d,
                            input logic [1:0] expResp, input string tag);
        iWrite = 1'b1; iAddr = addrOf(ch, rg); iWdata = d;
        @(posedge iClock);
        @(negedge iClock);
        iWrite = 1'b0;
        check(tag, {30'b0, oResp}, {30'b0, expResp});
    endtask

    task automatic busRead(input int ch, input int rg, output logic [31:0] d, output logic [1:0] r);
        iRead = 1'b1; iAddr = addrOf(ch, rg);
        @(posedge iClock);
        @(negedge iClock);
        iRead = 1'b0;
        d = oRdata; r = oResp;
    endtask

    task automatic runScenario(input int ch, input bit dir, input int tgtRaw, input int nCycles,
                               input bit withReset);
        int tgt, cur, ph, rg;
        bit inDead, running, pend;
        logic [5:0] g;
        logic [31:0] pendExp;
        if (withReset) doReset();
        tgt = (tgtRaw < cMin) ? cMin : tgtRaw;
        busWrite(ch, rTarget, 32'(tgtRaw), 2'b00, "tgtWrResp");
        busWrite(ch, rCtrl, {30'b0, dir, 1'b1}, 2'b00, "ctrlWrResp");
        pend = 1'b0; pendExp = '0;
        for (int n = 0; n <= nCycles; n++) begin
            if (n > 0) @(negedge iClock);
            iRead = 1'b0;
            if (pend) begin
                check("runRdata", oRdata, pendExp);
                check("runRresp", {30'b0, oResp}, 32'd0);
                pend = 1'b0;
            end
            model(n, dir, tgt, g, cur, ph, inDead, running);
            checkGates("runGates", ch, g);
            if ((n % 20 == 7) || ($urandom_range(0, 7) == 0)) begin
                rg = ($urandom_range(0, 1) == 0) ? rCurrent : rStatus;
                iRead = 1'b1; iAddr = addrOf(ch, rg);
                pendExp = (rg == rCurrent) ? 32'(cur)
                                           : statusWord(ph, running && (cur == tgt), running, inDead);
                pend = 1'b1;
            end
        end
        if (pend) begin
            @(negedge iClock);
            iRead = 1'b0;
            check("runRdata", oRdata, pendExp);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        @(negedge iClock);
        doReset();

        // Reset state and register map.
        check("rstRdata", oRdata, 32'd0);
        check("rstResp", {30'b0, oResp}, 32'd0);
        checkGates("rstGates", -1, 6'b0);
        busRead(0, rStatus, d, r);
        check("rstStatus", d, 32'h000);
        check("rstStatusResp", {30'b0, r}, 32'd0);
        busRead(0, rCurrent, d, r);
        check("rstCurrent", d, 32'(cStart));
        busRead(0, rTarget, d, r);
        check("rstTarget", d, 32'(cStart));

        busWrite(0, rTarget, 32'd5, 2'b00, "minWrResp");
        busRead(0, rTarget, d, r);
        check("minFloor", d, 32'(cMin));
        busWrite(0, rStatus, 32'h7ff, 2'b10, "roStatusResp");
        busRead(0, rStatus, d, r);
        check("roStatusKept", d, 32'h000);
        busWrite(1, rCurrent, 32'd55, 2'b10, "roCurrentResp");
        busRead(1, rCurrent, d, r);
        check("roCurrentKept", d, 32'(cStart));
        busWrite(3, rCtrl, 32'd1, 2'b10, "oorWrResp");
        busRead(3, rCtrl, d, r);
        check("oorRdata", d, 32'd0);
        check("oorRresp", {30'b0, r}, 32'(2'b10));
        busRead(0, rCtrl, d, r);
        check("oorNoAlias", d, 32'd0);

        // Simultaneous read and write: write wins, read returns 0 with OKAY.
        iRead = 1'b1; iWrite = 1'b1; iAddr = addrOf(2, rCtrl); iWdata = 32'd2;
        @(posedge iClock);
        @(negedge iClock);
        iRead = 1'b0; iWrite = 1'b0;
        check("rwRdata", oRdata, 32'd0);
        check("rwResp", {30'b0, oResp}, 32'd0);
        busRead(2, rCtrl, d, r);
        check("rwCtrl", d, 32'd2);
        @(negedge iClock);
        check("rdHold", oRdata, 32'd2);

        // Motor runs against the step-schedule model.
        runScenario(1, 1'b0, 50, 420, 1'b1);
        runScenario(0, 1'b1, 150, 500, 1'b1);
        for (int i = 0; i < 3; i++) begin
            runScenario(int'($urandom_range(0, cCh - 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(1, 200)), 300, 1'b1);
        end

        // Brake mid-drive, then release through dead time.
        doReset();
        busWrite(0, rCtrl, 32'd1, 2'b00, "brkEnResp");
        repeat (49) @(negedge iClock);
        busWrite(0, rCtrl, 32'd5, 2'b00, "brkOnResp");
        checkGates("brkPre", 0, 6'b100100);
        @(negedge iClock);
        checkGates("brkOn", 0, 6'b010101);
        repeat (5) @(negedge iClock);
        checkGates("brkHold", 0, 6'b010101);
        busRead(0, rStatus, d, r);
        check("brkStatus", d, 32'h300);
        busWrite(0, rCtrl, 32'd1, 2'b00, "brkOffResp");
        checkGates("brkOffEdge", 0, 6'b010101);
        @(negedge iClock);
        checkGates("brkDead1", 0, 6'b0);
        repeat (3) @(negedge iClock);
        checkGates("brkDead4", 0, 6'b0);
        @(negedge iClock);
        checkGates("brkResume", 0, 6'b100100);
        repeat (99) @(negedge iClock);
        checkGates("brkStepEnd", 0, 6'b100100);
        @(negedge iClock);
        checkGates("brkNextDead", 0, 6'b0);

        // Reset in the middle of a dead gap, then a clean restart.
        doReset();
        busWrite(2, rCtrl, 32'd1, 2'b00, "rstEnResp");
        repeat (102) @(negedge iClock);
        checkGates("preRstDead", 2, 6'b0);
        busRead(2, rStatus, d, r);
        check("preRstStatus", d, 32'h701);
        iReset_n = 1'b0;
        @(negedge iClock);
        checkGates("midRstGates", -1, 6'b0);
        check("midRstResp", {30'b0, oResp}, 32'd0);
        iReset_n = 1'b1;
        busRead(2, rStatus, d, r);
        check("postRstStatus", d, 32'h000);
        busRead(2, rCtrl, d, r);
        check("postRstCtrl", d, 32'd0);
        runScenario(2, 1'b0, 100, 250, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
